// File: rtl/fp_operand_issue.sv
// -----------------------------------------------------------------------------
// fp_operand_issue
//
// Upstream stage of the float adder. Operand pairs (A,B) arrive on a
// valid/ready handshake and are buffered in a small FIFO. One pair at a time is
// popped, classified and held stable on op_A_out/op_B_out long enough for the
// adder's multi-cycle READ..CHECK sequence to finish.
//
// Operand format, bit 0 = MSB in the adder's [0:31] numbering. In this file's
// [31:0] numbering: [31] sign, [30:25] exponent, [24:0] mantissa. The hidden 1
// is not stored.
//
// Optional feature: define FP_PREORDER_EN to reorder each popped pair so that
// op_A_out carries the larger magnitude. Without it, op_swapped is tied to 0.
//
// Parameters
//   DEPTH        FIFO entries, power of 2, 2..4 (fifo_count is 3 bits)
//   HOLD_CYCLES  cycles a pair stays in HOLD after the LOAD cycle, >= 32
//
// Ports
//   clock_100kHz  in   1   sole clock, rising edge
//   reset         in   1   synchronous, active-high
//   in_valid      in   1   in_op_a/in_op_b valid
//   in_ready      out  1   FIFO can accept a pair this cycle
//   in_op_a       in   32  operand A
//   in_op_b       in   32  operand B
//   op_A_out      out  32  operand A to the adder
//   op_B_out      out  32  operand B to the adder
//   issue_start   out  1   one-cycle pulse after a new pair is loaded
//   issue_busy    out  1   a pair is being held (LOAD or HOLD)
//   class_a       out  2   00 normal, 01 zero, 10 max-exp, 11 denorm
//   class_b       out  2   same encoding, for op_B_out
//   op_swapped    out  1   the pair on op_*_out was reordered
//   fifo_count    out  3   entries stored, 0..DEPTH
// -----------------------------------------------------------------------------
module fp_operand_issue #(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 40
) (
  input  logic        clock_100kHz,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_op_a,
  input  logic [31:0] in_op_b,
  output logic [31:0] op_A_out,
  output logic [31:0] op_B_out,
  output logic        issue_start,
  output logic        issue_busy,
  output logic [1:0]  class_a,
  output logic [1:0]  class_b,
  output logic        op_swapped,
  output logic [2:0]  fifo_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(HOLD_CYCLES);
  localparam logic [2:0]       DEPTH_C   = 3'(DEPTH);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  // Field extraction and classification. Sign is ignored, so -0 is a zero.
  function automatic logic [5:0] exp_of(input logic [31:0] x);
    return x[30:25];
  endfunction

  function automatic logic [24:0] mant_of(input logic [31:0] x);
    return x[24:0];
  endfunction

  function automatic logic [1:0] classify(input logic [31:0] x);
    logic [1:0] c;
    if (exp_of(x) == 6'd63)
      c = 2'b10;
    else if (exp_of(x) == 6'd0)
      c = (mant_of(x) == 25'd0) ? 2'b01 : 2'b11;
    else
      c = 2'b00;
    return c;
  endfunction

  // FIFO storage holds data only and is never reset; validity is tracked by
  // the pointers and count.
  logic [31:0] mem_a_q [DEPTH];
  logic [31:0] mem_b_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0]       count_q, count_d;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_q, start_d;

  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic [1:0]  cls_a_q, cls_a_d;
  logic [1:0]  cls_b_q, cls_b_d;
  logic        swapped_q, swapped_d;

  logic        push;
  logic        pop;
  logic        swap;
  logic [31:0] head_a;
  logic [31:0] head_b;

  // in_ready depends on registered state only, so a pop in the same cycle
  // never lets a full FIFO accept.
  assign in_ready = (count_q < DEPTH_C);
  assign push     = in_valid && in_ready;
  assign head_a   = mem_a_q[rd_ptr_q];
  assign head_b   = mem_b_q[rd_ptr_q];

`ifdef FP_PREORDER_EN
  // Larger exponent wins; equal exponents fall back to the mantissa.
  assign swap = (exp_of(head_b) > exp_of(head_a)) ||
                ((exp_of(head_b) == exp_of(head_a)) &&
                 (mant_of(head_b) > mant_of(head_a)));
`else
  assign swap = 1'b0;
`endif

  // FSM next state and hold counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != 3'd0) begin
          pop     = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d   = HOLD_LAST;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (cnt_q == '0)
          state_d = S_IDLE;
        else
          cnt_d = cnt_q - CNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The pulse is registered from LOAD, so it is seen in the first HOLD cycle.
  assign start_d = (state_q == S_LOAD);

  // FIFO bookkeeping
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push)
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  // Output registers change only on a pop and otherwise hold through IDLE.
  always_comb begin
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    cls_a_d   = cls_a_q;
    cls_b_d   = cls_b_q;
    swapped_d = swapped_q;
    if (pop) begin
      op_a_d    = swap ? head_b : head_a;
      op_b_d    = swap ? head_a : head_b;
      cls_a_d   = classify(swap ? head_b : head_a);
      cls_b_d   = classify(swap ? head_a : head_b);
      swapped_d = swap;
    end
  end

  always_ff @(posedge clock_100kHz) begin
    if (push) begin
      mem_a_q[wr_ptr_q] <= in_op_a;
      mem_b_q[wr_ptr_q] <= in_op_b;
    end
  end

  always_ff @(posedge clock_100kHz) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      start_q   <= 1'b0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      cls_a_q   <= '0;
      cls_b_q   <= '0;
      swapped_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      start_q   <= start_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      cls_a_q   <= cls_a_d;
      cls_b_q   <= cls_b_d;
      swapped_q <= swapped_d;
    end
  end

  assign op_A_out    = op_a_q;
  assign op_B_out    = op_b_q;
  assign class_a     = cls_a_q;
  assign class_b     = cls_b_q;
  assign op_swapped  = swapped_q;
  assign issue_start = start_q;
  assign issue_busy  = (state_q != S_IDLE);
  assign fifo_count  = count_q;

endmodule
